// File: rtl/icmp_echo_request.sv
// ICMP echo-request initiator. Computes the ICMP checksum over a fixed
// header plus a deterministic payload (byte i = i[7:0]) and streams the
// message to the IP transmit layer using the req/ack/ready/data-req/end
// byte handshake.
module icmp_echo_request #(
  parameter int          PAYLOAD_LEN = 32,
  parameter logic [15:0] ICMP_ID     = 16'h0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ping_req,
  output logic        ping_busy,
  output logic [15:0] seq_num,
  output logic        icmp_tx_req,
  input  logic        ip_tx_ack,
  output logic        icmp_tx_ready,
  input  logic        icmp_data_req,
  output logic [7:0]  icmp_tx_data,
  output logic        icmp_tx_end,
  output logic [15:0] icmp_send_data_length,
  input  logic        mac_send_end
);

  localparam int          NUM_WORDS = (PAYLOAD_LEN + 1) / 2;
  localparam logic [10:0] LAST_WORD = 11'(NUM_WORDS - 1);
  localparam bit          ODD_LEN   = (PAYLOAD_LEN % 2) == 1;
  localparam logic [15:0] TOTAL_LEN = 16'(8 + PAYLOAD_LEN);
  localparam logic [15:0] LAST_BYTE = 16'(7 + PAYLOAD_LEN);

  typedef enum logic [2:0] {IDLE, CALC, FOLD, REQ, SEND, DONE} state_t;

  state_t      state;
  logic [31:0] sum;
  logic [10:0] widx;
  logic [15:0] checksum;
  logic [15:0] byte_cnt;

  logic [7:0]  word_hi;
  logic [7:0]  word_lo;
  logic [16:0] s1;
  logic [15:0] s2;
  logic [7:0]  pl_byte;
  logic [7:0]  send_byte;

  assign icmp_send_data_length = TOTAL_LEN;
  assign ping_busy             = (state != IDLE);

  // Current payload word: bytes 2k and 2k+1, low byte zero-padded on an odd tail
  always_comb begin
    word_hi = {widx[6:0], 1'b0};
    word_lo = (ODD_LEN && (widx == LAST_WORD)) ? 8'h00 : {widx[6:0], 1'b1};
  end

  // Two end-around carry folds of the 32-bit accumulator
  always_comb begin
    s1 = {1'b0, sum[15:0]} + {1'b0, sum[31:16]};
    s2 = s1[15:0] + {15'd0, s1[16]};
  end

  // Byte to put on the wire for the current byte counter value
  always_comb begin
    pl_byte = byte_cnt[7:0] - 8'd8;
    case (byte_cnt)
      16'd0:   send_byte = 8'h08;
      16'd1:   send_byte = 8'h00;
      16'd2:   send_byte = checksum[15:8];
      16'd3:   send_byte = checksum[7:0];
      16'd4:   send_byte = ICMP_ID[15:8];
      16'd5:   send_byte = ICMP_ID[7:0];
      16'd6:   send_byte = seq_num[15:8];
      16'd7:   send_byte = seq_num[7:0];
      default: send_byte = pl_byte;
    endcase
  end

  // Control FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sum           <= '0;
      widx          <= '0;
      checksum      <= '0;
      byte_cnt      <= '0;
      seq_num       <= '0;
      icmp_tx_req   <= 1'b0;
      icmp_tx_ready <= 1'b0;
      icmp_tx_data  <= '0;
      icmp_tx_end   <= 1'b0;
    end else begin
      icmp_tx_end <= 1'b0;
      case (state)
        IDLE: begin
          if (ping_req) begin
            sum   <= 32'h0000_0800 + {16'h0000, ICMP_ID} + {16'h0000, seq_num};
            widx  <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          sum <= sum + {16'h0000, word_hi, word_lo};
          if (widx == LAST_WORD) begin
            state <= FOLD;
          end else begin
            widx <= widx + 11'd1;
          end
        end
        FOLD: begin
          checksum    <= ~s2;
          icmp_tx_req <= 1'b1;
          state       <= REQ;
        end
        REQ: begin
          if (ip_tx_ack) begin
            icmp_tx_req   <= 1'b0;
            icmp_tx_ready <= 1'b1;
            byte_cnt      <= '0;
            state         <= SEND;
          end
        end
        SEND: begin
          if (icmp_data_req) begin
            icmp_tx_data <= send_byte;
            byte_cnt     <= byte_cnt + 16'd1;
            if (byte_cnt == LAST_BYTE) begin
              icmp_tx_end   <= 1'b1;
              icmp_tx_ready <= 1'b0;
              state         <= DONE;
            end
          end
        end
        DONE: begin
          if (mac_send_end) begin
            seq_num <= seq_num + 16'd1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icmp_echo_request.sv
// Directed bench for icmp_echo_request: three instances cover the even,
// odd-padded and carry-fold payload configurations.
module tb_icmp_echo_request;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ping4, ack4, mend4, ping_s;
  logic        one;
  logic        dreq [3];
  logic        busy [3];
  logic        rdy  [3];
  logic        req  [3];
  logic        tend [3];
  logic [15:0] seq  [3];
  logic [15:0] len  [3];
  logic [7:0]  dat  [3];

  assign one = 1'b1;

  int checks   = 0;
  int failures = 0;

  logic [7:0] qs [3][$];
  bit         es [3][$];
  int         ecnt [3];

  icmp_echo_request #(.PAYLOAD_LEN(4), .ICMP_ID(16'h0001)) u4 (
    .clk(clk), .rst_n(rst_n), .ping_req(ping4), .ping_busy(busy[0]),
    .seq_num(seq[0]), .icmp_tx_req(req[0]), .ip_tx_ack(ack4),
    .icmp_tx_ready(rdy[0]), .icmp_data_req(dreq[0]), .icmp_tx_data(dat[0]),
    .icmp_tx_end(tend[0]), .icmp_send_data_length(len[0]), .mac_send_end(mend4));

  icmp_echo_request #(.PAYLOAD_LEN(3), .ICMP_ID(16'h0001)) u3 (
    .clk(clk), .rst_n(rst_n), .ping_req(ping_s), .ping_busy(busy[1]),
    .seq_num(seq[1]), .icmp_tx_req(req[1]), .ip_tx_ack(one),
    .icmp_tx_ready(rdy[1]), .icmp_data_req(dreq[1]), .icmp_tx_data(dat[1]),
    .icmp_tx_end(tend[1]), .icmp_send_data_length(len[1]), .mac_send_end(one));

  icmp_echo_request #(.PAYLOAD_LEN(2), .ICMP_ID(16'hFFFF)) u2 (
    .clk(clk), .rst_n(rst_n), .ping_req(ping_s), .ping_busy(busy[2]),
    .seq_num(seq[2]), .icmp_tx_req(req[2]), .ip_tx_ack(one),
    .icmp_tx_ready(rdy[2]), .icmp_data_req(dreq[2]), .icmp_tx_data(dat[2]),
    .icmp_tx_end(tend[2]), .icmp_send_data_length(len[2]), .mac_send_end(one));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Capture every transferred byte; check data holds while the IP layer pauses
  for (genvar g = 0; g < 3; g++) begin : mon
    logic [7:0] hold;
    always @(posedge clk) begin
      if (rdy[g] && dreq[g]) begin
        #1;
        qs[g].push_back(dat[g]);
        es[g].push_back(tend[g]);
      end else if (rdy[g] && !dreq[g]) begin
        hold = dat[g];
        #1;
        chk($sformatf("hold%0d", g), {24'd0, dat[g]}, {24'd0, hold});
      end
    end
  end

  // Count cycles with the end pulse high
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) if (tend[k] === 1'b1) ecnt[k]++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  typedef struct {
    int          ack_dly;
    bit          toggle;
    bit          ping_in_send;
    bit          preload;
    logic [95:0] exp;
    logic [15:0] seq_after;
  } vec_t;

  vec_t tbl [4];

  task automatic cmp_stream(input int k, input string nm, input logic [95:0] exp,
                            input int nlen, input int n);
    chk({nm, "_nbytes"}, qs[k].size(), n);
    for (int j = 0; j < n; j++) begin
      if (j < qs[k].size()) begin
        chk($sformatf("%s_byte%0d", nm, j), {24'd0, qs[k][j]}, {24'd0, exp[8*(nlen-1-j) +: 8]});
        chk($sformatf("%s_end%0d", nm, j), {31'd0, es[k][j]}, {31'd0, (j == nlen-1)});
      end
    end
    chk({nm, "_end_count"}, ecnt[k], (n == nlen) ? 1 : 0);
    qs[k].delete();
    es[k].delete();
    ecnt[k] = 0;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_busy"},  {31'd0, busy[0]}, 0);
    chk({nm, "_seq"},   {16'd0, seq[0]},  0);
    chk({nm, "_req"},   {31'd0, req[0]},  0);
    chk({nm, "_ready"}, {31'd0, rdy[0]},  0);
    chk({nm, "_data"},  {24'd0, dat[0]},  0);
    chk({nm, "_end"},   {31'd0, tend[0]}, 0);
  endtask

  task automatic run_exchange(input int ack_dly, input bit toggle, input bit ping_in_send,
                              input logic [15:0] seq_after, input string nm);
    int n;
    logic [3:0] pat;
    pat = 4'b1001;
    @(negedge clk);
    ping4 = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      ping4 = 1'b0;
      n++;
    end while (!req[0] && n < 50);
    chk({nm, "_req_latency"}, n, 4);
    chk({nm, "_busy"}, {31'd0, busy[0]}, 1);
    repeat (ack_dly) @(posedge clk);
    #1;
    chk({nm, "_req_held"}, {31'd0, req[0]}, 1);
    chk({nm, "_ready_pre"}, {31'd0, rdy[0]}, 0);
    ack4 = 1'b1;
    @(posedge clk); #1;
    ack4 = 1'b0;
    chk({nm, "_req_drop"}, {31'd0, req[0]}, 0);
    chk({nm, "_ready"}, {31'd0, rdy[0]}, 1);
    n = 0;
    while (rdy[0] && n < 100) begin
      dreq[0] = toggle ? pat[n % 4] : 1'b1;
      ping4   = ping_in_send && (n == 2);
      @(posedge clk); #1;
      ping4 = 1'b0;
      n++;
    end
    dreq[0] = 1'b0;
    chk({nm, "_stream_done"}, {31'd0, rdy[0]}, 0);
    chk({nm, "_end_last"}, {31'd0, tend[0]}, 1);
    @(posedge clk); #1;
    chk({nm, "_end_drop"}, {31'd0, tend[0]}, 0);
    chk({nm, "_busy_done"}, {31'd0, busy[0]}, 1);
    mend4 = 1'b1;
    @(posedge clk); #1;
    mend4 = 1'b0;
    chk({nm, "_idle"}, {31'd0, busy[0]}, 0);
    chk({nm, "_seq_after"}, {16'd0, seq[0]}, {16'd0, seq_after});
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_no_queued_ping"}, {31'd0, busy[0]}, 0);
  endtask

  task automatic apply_vec(input int i);
    string nm;
    nm = $sformatf("ex%0d", i);
    if (tbl[i].preload) begin
      @(negedge clk);
      force u4.seq_num = 16'hFFFF;
      @(posedge clk); #1;
      release u4.seq_num;
      #1;
      chk({nm, "_preload"}, {16'd0, seq[0]}, 32'h0000_FFFF);
    end
    run_exchange(tbl[i].ack_dly, tbl[i].toggle, tbl[i].ping_in_send, tbl[i].seq_after, nm);
    cmp_stream(0, nm, tbl[i].exp, 12, 12);
  endtask

  initial begin
    int n;
    tbl[0] = '{3, 1'b0, 1'b0, 1'b0, 96'h08_00_F5_FA_00_01_00_00_00_01_02_03, 16'h0001};
    tbl[1] = '{0, 1'b1, 1'b0, 1'b0, 96'h08_00_F5_F9_00_01_00_01_00_01_02_03, 16'h0002};
    tbl[2] = '{1, 1'b0, 1'b1, 1'b0, 96'h08_00_F5_F8_00_01_00_02_00_01_02_03, 16'h0003};
    tbl[3] = '{2, 1'b1, 1'b0, 1'b1, 96'h08_00_F5_FA_00_01_FF_FF_00_01_02_03, 16'h0000};

    rst_n = 1'b0; ping4 = 1'b0; ack4 = 1'b0; mend4 = 1'b0; ping_s = 1'b0;
    dreq[0] = 1'b0; dreq[1] = 1'b1; dreq[2] = 1'b1;
    for (int k = 0; k < 3; k++) ecnt[k] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    chk("len_pl4", {16'd0, len[0]}, 12);
    chk("len_pl3", {16'd0, len[1]}, 11);
    chk("len_pl2", {16'd0, len[2]}, 10);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) apply_vec(i);

    // Reset in the middle of SEND, after five bytes of the seq=3 message
    @(negedge clk);
    ping4 = 1'b1;
    @(posedge clk); #1;
    ping4 = 1'b0;
    n = 0;
    while (!req[0] && n < 50) begin @(posedge clk); #1; n++; end
    chk("rst_req_seen", {31'd0, req[0]}, 1);
    ack4 = 1'b1;
    @(posedge clk); #1;
    ack4 = 1'b0;
    dreq[0] = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midsend_reset");
    dreq[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cmp_stream(0, "midsend", 96'h08_00_F5_F7_00_01_00_03_00_01_02_03, 12, 5);
    run_exchange(1, 1'b0, 1'b0, 16'h0001, "post_rst");
    cmp_stream(0, "post_rst", 96'h08_00_F5_FA_00_01_00_00_00_01_02_03, 12, 12);

    apply_vec(3);

    // Odd-length padding and carry-fold instances, free-running handshake
    @(negedge clk);
    ping_s = 1'b1;
    @(negedge clk);
    ping_s = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    cmp_stream(1, "pl3", {8'h00, 88'h08_00_F5_FD_00_01_00_00_00_01_02}, 11, 11);
    cmp_stream(2, "pl2", {16'h0000, 80'h08_00_F7_FE_FF_FF_00_00_00_01}, 10, 10);
    chk("pl3_seq_after", {16'd0, seq[1]}, 1);
    chk("pl2_seq_after", {16'd0, seq[2]}, 1);
    chk("pl3_idle", {31'd0, busy[1]}, 0);
    chk("pl2_idle", {31'd0, busy[2]}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icmp_echo_request.md
# icmp_echo_request

ICMP echo-request (ping) initiator for the Ethernet full-duplex subsystem; it is the counterpart to the existing ICMP echo responder. On a user request it computes the ICMP checksum over a fixed header and a deterministic payload. It then hands the message to the IP/MAC transmit path with the same req/ack/ready/data-req/end byte handshake the responder uses. It runs in the `gmii_tx_clk` domain.

## Interface
- PAYLOAD_LEN, 32: payload bytes after the 8-byte ICMP header; legal range 1..1472.
- ICMP_ID, 16'h0001: identifier field.
- clk  in  1  transmit clock (`gmii_tx_clk`).
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- ping_req  in  1  start pulse; sampled only in IDLE.
- ping_busy  out  1  high in every state except IDLE.
- seq_num  out  16  sequence number of the current or next request.
- icmp_tx_req  out  1  request to the IP transmit layer.
- ip_tx_ack  in  1  IP layer accepts the request.
- icmp_tx_ready  out  1  message ready to stream.
- icmp_data_req  in  1  IP layer requests one byte per high cycle.
- icmp_tx_data  out  8  message byte (registered).
- icmp_tx_end  out  1  one-cycle pulse coincident with the last byte.
- icmp_send_data_length  out  16  constant 8+PAYLOAD_LEN.
- mac_send_end  in  1  MAC finished the frame.

## Operation
- States: IDLE, CALC, FOLD, REQ, SEND, DONE.
- IDLE, ping_req=1:
  - latch seq_num;
  - sum[31:0] <= 0x0800 + ICMP_ID + seq_num;
  - word index <= 0;
  - go to CALC.
- CALC: adds one payload word per cycle.
  - Payload byte i = i[7:0].
  - Word k = {byte 2k, byte 2k+1}.
  - If PAYLOAD_LEN is odd, the final word is {last byte, 8'h00}.
  - After ceil(PAYLOAD_LEN/2) words, go to FOLD.
- FOLD (1 cycle):
  - s1 = sum[15:0] + sum[31:16];
  - s2 = s1[15:0] + s1[16];
  - checksum <= ~s2[15:0];
  - go to REQ.
- REQ:
  - icmp_tx_req=1 until ip_tx_ack is sampled high, then icmp_tx_req=0 and icmp_tx_ready=1;
  - go to SEND.
- SEND: byte order is 08, 00, cks[15:8], cks[7:0], ID[15:8], ID[7:0], seq[15:8], seq[7:0], payload 0..PAYLOAD_LEN-1.
  - A byte counter advances only on cycles with icmp_data_req=1.
  - icmp_data_req low pauses the stream; icmp_tx_data holds its value.
  - On the last byte (counter = 8+PAYLOAD_LEN-1), icmp_tx_end=1, icmp_tx_ready=0, go to DONE.
- DONE:
  - wait for mac_send_end=1, then seq_num <= seq_num+1 (wraps 0xFFFF -> 0x0000);
  - go to IDLE.
- ping_req outside IDLE is ignored; it is not queued.
- icmp_data_req outside SEND is ignored.
- ip_tx_ack outside REQ is ignored.
- Reset mid-operation: return to IDLE immediately, seq_num = 0, no icmp_tx_end issued.

## Timing
- Reset values: ping_busy=0, seq_num=0, icmp_tx_req=0, icmp_tx_ready=0, icmp_tx_data=0, icmp_tx_end=0.
- icmp_send_data_length is constant 8+PAYLOAD_LEN, independent of reset.
- ping_req sampled at edge T:
  - CALC occupies T+1..T+W, where W = ceil(PAYLOAD_LEN/2);
  - FOLD is at T+W+1;
  - icmp_tx_req goes high at T+W+2.
- ip_tx_ack sampled at edge A: icmp_tx_req low and icmp_tx_ready high from A+1.
- Byte latency: icmp_data_req high at edge D -> the byte is on icmp_tx_data from D+1.
- Continuous icmp_data_req gives 8+PAYLOAD_LEN back-to-back bytes. icmp_tx_end is high for exactly the last byte's cycle.
- mac_send_end sampled at edge E: ping_busy low and seq_num incremented at E+1. A new ping_req is accepted at E+1.
- Arithmetic: a 32-bit accumulator cannot overflow for PAYLOAD_LEN <= 1472; both carry folds are mandatory.

## Test plan
- PAYLOAD_LEN=4, ID=0x0001, seq=0, ping_req pulse, ip_tx_ack 3 cycles after icmp_tx_req, icmp_data_req held high:
  - icmp_tx_req rises exactly 4 cycles after ping_req;
  - bytes are 08 00 F5 FA 00 01 00 00 00 01 02 03;
  - icmp_tx_end coincides with byte 03;
  - icmp_send_data_length=12.
- PAYLOAD_LEN=3 (odd padding), ID=0x0001, seq=0 -> checksum bytes F5 FD; 11 bytes total; the last byte is 02.
- PAYLOAD_LEN=2, ID=0xFFFF, seq=0 -> sum 0x10800 folds to 0x0801; checksum bytes F7 FE.
- Back-pressure: toggle icmp_data_req 1-0-0-1 during the PAYLOAD_LEN=4 stream -> same 12-byte sequence, data held while low, exactly one icmp_tx_end.
- Sequence handling: ping_req during SEND is ignored. Three full exchanges give seq 0,1,2 in the header and seq_num=3 after the third mac_send_end. Preloading seq 0xFFFF wraps to 0x0000.
- Reset asserted mid-SEND, after 5 bytes -> all outputs return to reset values on the asynchronous edge; no icmp_tx_end is issued; the next ping after reset uses seq 0.
